// File: rtl/parking_spot_allocator.sv
// Parking spot allocator: tracks spot occupancy, assigns the lowest free spot
// to each car-entry request, and drives a held LED enable plus spot code (or a
// held reject strobe when the lot is full). Exits release spots in any state.
module parking_spot_allocator #(
    parameter int NUM_SPOTS   = 6,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entry,
    input  logic       exit_valid,
    input  logic [3:0] exit_spot,
    output logic       led,
    output logic [3:0] pasignado,
    output logic       reject,
    output logic [5:0] occupancy,
    output logic [2:0] free_count,
    output logic       full
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_ASSIGN = 2'd2,
        ST_REJECT = 2'd3
    } state_t;

    localparam logic [5:0] SPOT_MASK = 6'((1 << NUM_SPOTS) - 1);
    localparam logic [9:0] HOLD_LAST = 10'(HOLD_CYCLES - 1);
    localparam logic [2:0] SPOTS_W3  = 3'(NUM_SPOTS);
    localparam logic [3:0] SPOTS_W4  = 4'(NUM_SPOTS);

    // Number of set bits in an occupancy vector.
    function automatic logic [2:0] popcount6(input logic [5:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 6; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    state_t     state_q, state_d;
    logic       entry_q, entry_d;
    logic       pending_q, pending_d;
    logic [2:0] idx_q, idx_d;
    logic [9:0] hold_q, hold_d;
    logic       led_q, led_d;
    logic [3:0] pas_q, pas_d;
    logic       reject_q, reject_d;
    logic [5:0] occ_q, occ_d;
    logic [2:0] free_q, free_d;

    logic       request_s;
    logic       spot_free_s;
    logic [7:0] occ_ext_s;
    logic [5:0] set_mask_s;
    logic [5:0] clr_mask_s;
    logic       exit_hit_s;

    // Request edge detect and lookup of the spot under the scan index.
    always_comb begin
        entry_d     = entry;
        request_s   = entry & ~entry_q;
        occ_ext_s   = {2'b00, occ_q};
        spot_free_s = ~occ_ext_s[idx_q - 3'd1];
    end

    // FSM next state: request acceptance, spot search, hold timing, pending flag.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        led_d      = led_q;
        pas_d      = pas_q;
        reject_d   = reject_q;
        set_mask_s = 6'd0;

        if (request_s && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (request_s || pending_q) begin
                    pending_d = 1'b0;
                    if (free_q == 3'd0) begin
                        state_d  = ST_REJECT;
                        reject_d = 1'b1;
                        hold_d   = 10'd0;
                    end else begin
                        state_d = ST_SEARCH;
                        idx_d   = 3'd1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if ((idx_q == 3'd0) || (idx_q > SPOTS_W3)) begin
                    // Unreachable while free_count > 0; recover to IDLE safely.
                    state_d = ST_IDLE;
                end else if (spot_free_s) begin
                    set_mask_s = 6'd1 << (idx_q - 3'd1);
                    led_d      = 1'b1;
                    pas_d      = {1'b0, idx_q};
                    hold_d     = 10'd0;
                    state_d    = ST_ASSIGN;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_ASSIGN: begin
                if (hold_q == HOLD_LAST) begin
                    led_d   = 1'b0;
                    pas_d   = 4'd0;
                    hold_d  = 10'd0;
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 10'd1;
                end
            end
            ST_REJECT: begin
                if (hold_q == HOLD_LAST) begin
                    reject_d = 1'b0;
                    hold_d   = 10'd0;
                    state_d  = ST_IDLE;
                end else begin
                    hold_d = hold_q + 10'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                led_d    = 1'b0;
                pas_d    = 4'd0;
                reject_d = 1'b0;
                hold_d   = 10'd0;
            end
        endcase
    end

    // Exit release and occupancy update; a set in the same cycle wins over a clear.
    always_comb begin
        exit_hit_s = exit_valid && (exit_spot >= 4'd1) && (exit_spot <= SPOTS_W4);
        if (exit_hit_s) begin
            clr_mask_s = 6'd1 << (exit_spot - 4'd1);
        end else begin
            clr_mask_s = 6'd0;
        end
        occ_d  = ((occ_q & ~clr_mask_s) | set_mask_s) & SPOT_MASK;
        free_d = SPOTS_W3 - popcount6(occ_d);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            entry_q   <= 1'b0;
            pending_q <= 1'b0;
            idx_q     <= 3'd0;
            hold_q    <= 10'd0;
            led_q     <= 1'b0;
            pas_q     <= 4'd0;
            reject_q  <= 1'b0;
            occ_q     <= 6'd0;
            free_q    <= SPOTS_W3;
        end else begin
            state_q   <= state_d;
            entry_q   <= entry_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            led_q     <= led_d;
            pas_q     <= pas_d;
            reject_q  <= reject_d;
            occ_q     <= occ_d;
            free_q    <= free_d;
        end
    end

    assign led        = led_q;
    assign pasignado  = pas_q;
    assign reject     = reject_q;
    assign occupancy  = occ_q;
    assign free_count = free_q;
    assign full       = (free_q == 3'd0);

endmodule
